// File: rtl/mhsa_pkg.sv
// -----------------------------------------------------------------------------
// mhsa_pkg
// Shared constants and types for the attention-block datapath.
//   WORD_W     : memory word width in bits
//   ROW_WORDS  : memory words per weight-matrix row
//   rd_state_e : weight reader sequencing states
// -----------------------------------------------------------------------------
package mhsa_pkg;

    localparam int WORD_W    = 64;
    localparam int ROW_WORDS = 16;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/wr_fifo2.sv
// -----------------------------------------------------------------------------
// wr_fifo2
// Two-entry synchronous FIFO with occupancy output.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full and not popping)
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : head entry; reads 0 after reset
//   empty      : no entries held
//   count      : number of entries held (0..2)
// -----------------------------------------------------------------------------
module wr_fifo2 #(
    parameter int WIDTH = mhsa_pkg::WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        // a full FIFO can still take a word when the head leaves in the same cycle
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/weight_reader.sv
// -----------------------------------------------------------------------------
// weight_reader
// Reads a weight matrix from word-addressed memory (fixed 1-cycle read latency)
// and streams it out with valid/ready, tagging each word with its row index
// and end-of-row / end-of-matrix markers.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | issuing reads while FIFO + in-flight occupancy allows
// DRAIN  | all addresses issued; waiting for the stream to empty, then done
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle request to read the whole matrix (IDLE only)
//   busy              : transfer in progress (through the done cycle)
//   done              : one-cycle pulse after the final word handshake
//   mem_write_en      : tied low, read-only master
//   mem_addr          : word address; holds its last value when not issuing
//   mem_data_out      : read data, valid one cycle after its address
//   out_valid/ready   : stream handshake
//   out_data          : stream word
//   out_row           : matrix row of out_data
//   out_last_row_word : out_data ends its row
//   out_last          : out_data ends the matrix
// -----------------------------------------------------------------------------
module weight_reader #(
    parameter int          WIDTH       = mhsa_pkg::WORD_W,
    parameter logic [31:0] WEIGHT_BASE = 32'd0,
    parameter int          WEIGHT_SIZE = 2048,
    parameter int          ROW_WORDS   = mhsa_pkg::ROW_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             mem_write_en,
    output logic [31:0]      mem_addr,
    input  logic [WIDTH-1:0] mem_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [6:0]       out_row,
    output logic             out_last_row_word,
    output logic             out_last
);

    import mhsa_pkg::*;

    localparam logic [1:0] S_IDLE  = RD_IDLE;
    localparam logic [1:0] S_FETCH = RD_FETCH;
    localparam logic [1:0] S_DRAIN = RD_DRAIN;

    // one extra state of headroom so the index can reach WEIGHT_SIZE without wrapping
    localparam int IDX_W = $clog2(WEIGHT_SIZE + 1);
    localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WEIGHT_SIZE - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
    logic             in_flight_q, in_flight_d;
    logic [31:0]      last_addr_q, last_addr_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [6:0]       row_q, row_d;

    logic [1:0]       fifo_count;
    logic             fifo_empty;
    logic             pop;
    logic [2:0]       occupancy;
    logic             issue;
    logic [31:0]      issue_addr;
    logic             drain_done;

    wr_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight_q),
        .push_data (mem_data_out),
        .pop       (pop),
        .pop_data  (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        pop        = !fifo_empty && out_ready;
        // words held or still coming back, minus the one leaving this cycle;
        // issuing only below 2 guarantees the FIFO can never overflow
        occupancy  = 3'(fifo_count) + 3'(in_flight_q) - 3'(pop);
        issue      = (state_q == S_FETCH) && (occupancy < 3'd2);
        issue_addr = WEIGHT_BASE + 32'(iss_idx_q);
        drain_done = (state_q == S_DRAIN) && fifo_empty && !in_flight_q;

        state_d     = state_q;
        iss_idx_d   = iss_idx_q;
        in_flight_d = issue;
        last_addr_d = issue ? issue_addr : last_addr_q;
        out_idx_d   = out_idx_q;
        col_d       = col_q;
        row_d       = row_q;

        if (issue) begin
            iss_idx_d = iss_idx_q + 1'b1;
        end

        if (pop) begin
            out_idx_d = out_idx_q + 1'b1;
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 7'd1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    iss_idx_d = '0;
                    out_idx_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                end
            end
            S_FETCH: begin
                if (issue && (iss_idx_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            iss_idx_q   <= '0;
            in_flight_q <= 1'b0;
            last_addr_q <= WEIGHT_BASE;
            out_idx_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            iss_idx_q   <= iss_idx_d;
            in_flight_q <= in_flight_d;
            last_addr_q <= last_addr_d;
            out_idx_q   <= out_idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    // the issued address goes out in the issue cycle itself so data returns next cycle
    assign mem_addr          = issue ? issue_addr : last_addr_q;
    assign mem_write_en      = 1'b0;
    assign busy              = (state_q != S_IDLE);
    assign done              = drain_done;
    assign out_valid         = !fifo_empty;
    assign out_row           = row_q;
    assign out_last_row_word = (col_q == LAST_COL);
    assign out_last          = (out_idx_q == LAST_IDX);

endmodule

// File: tb/tb_weight_reader.sv
module tb_weight_reader;

    localparam int SIZE = 2048;
    localparam int RW   = 16;

    logic        clk;
    logic        rst_n;
    logic        start, start2;
    logic        out_ready, ready2;

    logic        busy, done, mem_write_en, out_valid, out_last_row_word, out_last;
    logic [31:0] mem_addr;
    logic [63:0] mem_rd, out_data;
    logic [6:0]  out_row;

    logic        busy2, done2, mem_write_en2, out_valid2, out_lrw2, out_last2;
    logic [31:0] mem_addr2;
    logic [63:0] mem_rd2, out_data2;
    logic [6:0]  out_row2;

    weight_reader u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .busy (busy), .done (done),
        .mem_write_en (mem_write_en), .mem_addr (mem_addr), .mem_data_out (mem_rd),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_row (out_row), .out_last_row_word (out_last_row_word), .out_last (out_last)
    );

    weight_reader #(.WEIGHT_SIZE (1), .ROW_WORDS (1)) u_dut2 (
        .clk (clk), .rst_n (rst_n), .start (start2), .busy (busy2), .done (done2),
        .mem_write_en (mem_write_en2), .mem_addr (mem_addr2), .mem_data_out (mem_rd2),
        .out_valid (out_valid2), .out_ready (ready2), .out_data (out_data2),
        .out_row (out_row2), .out_last_row_word (out_lrw2), .out_last (out_last2)
    );

    // memory preloaded with word[a] = a, one-cycle read latency
    always @(posedge clk) begin
        mem_rd  <= 64'(mem_addr);
        mem_rd2 <= 64'(mem_addr2);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    int m_busy = 0, m_idx = 0, m_done_pend = 0, m_last_cnt = 0;
    int was_stall = 0;
    int start_cyc = 0, first_cyc = -1, done_cyc = -1;

    always @(negedge clk) begin
        int accept;
        if (!rst_n) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_data", out_data, 0);
            chk("rst_we", mem_write_en, 0);
            m_busy = 0; m_idx = 0; m_done_pend = 0; was_stall = 0;
        end else begin
            accept = (start && !m_busy) ? 1 : 0;
            chk("busy", busy, m_busy);
            chk("done", done, m_done_pend);
            chk("we", mem_write_en, 0);
            chk("fifo_le2", (u_dut.fifo_count <= 2'd2) ? 1 : 0, 1);
            if (!m_busy) chk("idle_valid", out_valid, 0);
            if (was_stall) chk("held_valid", out_valid, 1);
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("data", out_data, m_idx);
                chk("row", out_row, m_idx / RW);
                chk("last_row_word", out_last_row_word, ((m_idx % RW) == RW - 1) ? 1 : 0);
                chk("last", out_last, (m_idx == SIZE - 1) ? 1 : 0);
            end
            if (m_done_pend) begin
                m_done_pend = 0;
                m_busy      = 0;
                done_cyc    = cyc;
            end
            if (out_valid && out_ready) begin
                if (out_last) m_last_cnt++;
                m_idx++;
                if (m_idx == SIZE) m_done_pend = 1;
            end
            was_stall = (out_valid && !out_ready) ? 1 : 0;
            if (accept) begin
                m_busy = 1; m_idx = 0; m_last_cnt = 0;
                start_cyc = cyc; first_cyc = -1; done_cyc = -1;
            end
        end
    end

    // random ready driver
    int rmode = 0;
    always @(posedge clk) begin
        #1;
        if (rmode != 0) out_ready = 1'($urandom % 2);
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        int found = 0;
        while (n < bound && found == 0) begin
            @(negedge clk);
            if (done) found = 1;
            n++;
        end
        chk({name, "_done_seen"}, found, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_run(input string name, input int timed);
        chk({name, "_words"}, m_idx, SIZE);
        chk({name, "_last_cnt"}, m_last_cnt, 1);
        if (timed != 0) begin
            chk({name, "_first_lat"}, first_cyc - start_cyc, 3);
            chk({name, "_done_lat"}, done_cyc - start_cyc, 2051);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b0; ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_addr", mem_addr, 32'd0);
        chk("init_valid", out_valid, 0);
        chk("init_data", out_data, 0);

        // full read, ready held high
        out_ready = 1'b1;
        pulse_start();
        wait_done("full", 2200);
        check_run("full", 1);

        // second start during the transfer is ignored
        pulse_start();
        repeat (499) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("restart", 2200);
        check_run("restart", 1);

        // random back-pressure
        rmode = 1;
        pulse_start();
        wait_done("random", 20000);
        rmode = 0;
        @(posedge clk); #1 out_ready = 1'b1;
        check_run("random", 0);

        // consumer stalled for 20 cycles: exactly two reads outstanding
        out_ready = 1'b0;
        pulse_start();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_fifo_count", u_dut.fifo_count, 2);
        chk("stall_addr", mem_addr, 1);
        chk("stall_data", out_data, 0);
        chk("stall_valid", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("stall", 2200);
        check_run("stall", 0);

        // reset mid-transfer, then restart from the base address
        pulse_start();
        repeat (700) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_data", out_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_start();
        wait_done("after_reset", 2200);
        check_run("after_reset", 1);

        // single-word matrix instance
        ready2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (n < 10 && !out_valid2) begin
            @(negedge clk);
            n++;
        end
        chk("one_latency", n, 3);
        chk("one_data", out_data2, 0);
        chk("one_last", out_last2, 1);
        chk("one_lrw", out_lrw2, 1);
        chk("one_row", out_row2, 0);
        chk("one_done_at_hs", done2, 0);
        chk("one_we", mem_write_en2, 0);
        @(negedge clk);
        chk("one_done", done2, 1);
        chk("one_busy_in_done", busy2, 1);
        @(negedge clk);
        chk("one_done_clear", done2, 0);
        chk("one_busy_clear", busy2, 0);
        chk("one_valid_clear", out_valid2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
